universal_addsub_serial: RTL and testbench

- Parametrised, multi-cycle add/subtract unit; successor to the 4-bit combinational subtractor.
- Processes WIDTH-bit operands CHUNK bits per clock, carry chained through a register.
- Uses valid/ready handshakes on both input and output.
- Reports carry/borrow, signed overflow, zero and negative flags. Sits in the datapath where area matters more than latency.

---
 rtl/universal_addsub_serial.sv | 170 +++++++++++++++++
 tb/tb_universal_addsub_serial.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/universal_addsub_serial.sv
// universal_addsub_serial: multi-cycle two's-complement add/subtract unit.
// Operands of WIDTH bits are processed CHUNK bits per clock, LSB chunk first,
// with the inter-chunk carry held in a one-bit register. Valid/ready
// handshakes on both the operation input and the result output.
// Modes: 00 = A-B, 01 = A+B, 10 = B-A, 11 = 0-A.
// Optional feature: define UNIVERSAL_ADDSUB_SATURATE_EN to clamp the result
// on signed overflow instead of wrapping modulo 2^WIDTH.

module universal_addsub_serial #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_borrow,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] x_reg;
  logic [WIDTH-1:0] y_reg;
  logic [WIDTH-1:0] acc_reg;
  logic             carry_reg;
  logic             is_add;
  logic             x_msb;
  logic             y_msb;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] op_x;
  logic [WIDTH-1:0] op_y;
  logic [WIDTH-1:0] op_yp;
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] acc_next;
  logic             final_ovf;
  logic             final_cb;
  logic [WIDTH-1:0] final_res;

  // Map the requested mode onto a single X + Y' + carry-in form; subtraction
  // uses the inverted second operand together with a carry-in of one.
  always_comb begin
    op_x = a;
    op_y = b;
    case (mode)
      2'b10: begin
        op_x = b;
        op_y = a;
      end
      2'b11: begin
        op_x = '0;
        op_y = a;
      end
      default: begin
        op_x = a;
        op_y = b;
      end
    endcase
    op_yp = (mode == 2'b01) ? op_y : ~op_y;
  end

  // One chunk of the ripple sum, the accumulated result it produces and the
  // flags as they would look if this is the final chunk. Overflow compares
  // against the sign of Y' so one rule covers both addition and subtraction,
  // including negation of the most-negative value.
  always_comb begin
    chunk_sum = {1'b0, x_reg[CHUNK-1:0]} + {1'b0, y_reg[CHUNK-1:0]}
              + {{CHUNK{1'b0}}, carry_reg};
    acc_next  = (acc_reg >> CHUNK)
              | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
    final_ovf = (x_msb == y_msb) && (acc_next[WIDTH-1] != x_msb);
    final_cb  = is_add ? chunk_sum[CHUNK] : ~chunk_sum[CHUNK];
    final_res = acc_next;
`ifdef UNIVERSAL_ADDSUB_SATURATE_EN
    if (final_ovf) begin
      final_res = x_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // Control FSM plus the chunk datapath; operands shift right one chunk per
  // BUSY cycle so only the low chunk is ever added, and the visible result
  // and flags change only when an operation completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      result       <= '0;
      carry_borrow <= 1'b0;
      overflow     <= 1'b0;
      zero         <= 1'b0;
      negative     <= 1'b0;
      cnt          <= '0;
      x_reg        <= '0;
      y_reg        <= '0;
      acc_reg      <= '0;
      carry_reg    <= 1'b0;
      is_add       <= 1'b0;
      x_msb        <= 1'b0;
      y_msb        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_reg     <= op_x;
            y_reg     <= op_yp;
            acc_reg   <= '0;
            carry_reg <= (mode != 2'b01);
            is_add    <= (mode == 2'b01);
            x_msb     <= op_x[WIDTH-1];
            y_msb     <= op_yp[WIDTH-1];
            cnt       <= '0;
            in_ready  <= 1'b0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          x_reg     <= x_reg >> CHUNK;
          y_reg     <= y_reg >> CHUNK;
          acc_reg   <= acc_next;
          carry_reg <= chunk_sum[CHUNK];
          if (cnt == LAST_CHUNK) begin
            cnt          <= '0;
            result       <= final_res;
            carry_borrow <= final_cb;
            overflow     <= final_ovf;
            zero         <= (final_res == '0);
            negative     <= final_res[WIDTH-1];
            out_valid    <= 1'b1;
            state        <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_universal_addsub_serial.sv
// Self-checking bench for universal_addsub_serial (WIDTH = 16, CHUNK = 4).
// Expected results come from a signed/unsigned integer model of the
// arithmetic; a scoreboard queue decouples issuing operations from checking
// results. Define UNIVERSAL_ADDSUB_SATURATE_EN to check the saturating build.

module tb_universal_addsub_serial;

  localparam int W = 16;
  localparam int C = 4;
  localparam int N = W / C;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_borrow;
  logic         overflow;
  logic         zero;
  logic         negative;

  typedef struct {
    logic [W-1:0] res;
    logic         cb;
    logic         ovf;
    logic         zr;
    logic         neg;
  } exp_t;

  exp_t sb_q[$];
  int   checks;
  int   errors;

  universal_addsub_serial #(.WIDTH(W), .CHUNK(C)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a            (a),
    .b            (b),
    .mode         (mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .carry_borrow (carry_borrow),
    .overflow     (overflow),
    .zero         (zero),
    .negative     (negative)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic: true signed value decides overflow/saturation,
  // unsigned compare decides carry or borrow
  function automatic exp_t refModel(input logic [W-1:0] av, input logic [W-1:0] bv,
                                    input logic [1:0] m);
    exp_t         e;
    logic [W-1:0] xv;
    logic [W-1:0] yv;
    int           ux, uy, sx, sy, u, t;
    case (m)
      2'b10:   begin xv = bv;   yv = av; end
      2'b11:   begin xv = '0;   yv = av; end
      default: begin xv = av;   yv = bv; end
    endcase
    ux = int'(xv);
    uy = int'(yv);
    sx = int'($signed(xv));
    sy = int'($signed(yv));
    if (m == 2'b01) begin
      u    = ux + uy;
      t    = sx + sy;
      e.cb = (u > 65535);
    end else begin
      u    = ux - uy;
      t    = sx - sy;
      e.cb = (ux < uy);
    end
    e.res = u[W-1:0];
    e.ovf = (t > 32767) || (t < -32768);
`ifdef UNIVERSAL_ADDSUB_SATURATE_EN
    if (e.ovf) e.res = (t > 0) ? 16'h7FFF : 16'h8000;
`endif
    e.zr  = (e.res == '0);
    e.neg = e.res[W-1];
    return e;
  endfunction

  // Single comparison point for every check in the bench
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare each transferred result against the oldest expectation
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        checkOutput("result",       32'(result),       32'(e.res));
        checkOutput("carry_borrow", 32'(carry_borrow), 32'(e.cb));
        checkOutput("overflow",     32'(overflow),     32'(e.ovf));
        checkOutput("zero",         32'(zero),         32'(e.zr));
        checkOutput("negative",     32'(negative),     32'(e.neg));
      end
    end
  end

  // Wait for in_ready, present one operation for the accept edge, record it
  task automatic issueOp(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [1:0] m, output exp_t e);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) checkOutput("in_ready_timeout", 32'd0, 32'd1);
    a        = av;
    b        = bv;
    mode     = m;
    in_valid = 1'b1;
    e        = refModel(av, bv, m);
    sb_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges from accept until out_valid, bounded
  task automatic waitValid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Wait for the result transfer to complete, bounded
  task automatic waitTransfer();
    int n;
    n = 0;
    while (out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (out_valid) checkOutput("transfer_timeout", 32'd1, 32'd0);
  endtask

  // Full operation: issue, check latency, optionally stall the consumer
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic [1:0] m, input int hold);
    exp_t e;
    int   lat;
    out_ready = (hold == 0);
    issueOp(av, bv, m, e);
    waitValid(lat);
    checkOutput("latency", 32'(lat), 32'(N));
    repeat (hold) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    waitTransfer();
  endtask

  initial begin
    exp_t e;
    int   lat;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    mode      = 2'b00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    checkOutput("rst_in_ready",  32'(in_ready),     32'd1);
    checkOutput("rst_out_valid", 32'(out_valid),    32'd0);
    checkOutput("rst_result",    32'(result),       32'd0);
    checkOutput("rst_flags",     32'({carry_borrow, overflow, zero, negative}), 32'd0);

    // Directed cases from the test plan
    applyStimulus(16'h0005, 16'h0003, 2'b00, 0);
    applyStimulus(16'h0003, 16'h0005, 2'b00, 0);
    applyStimulus(16'h0003, 16'h0005, 2'b10, 0);
    applyStimulus(16'h8000, 16'h0001, 2'b00, 1);
    applyStimulus(16'h7FFF, 16'h0001, 2'b01, 0);
    applyStimulus(16'hFFFF, 16'h0001, 2'b01, 0);
    applyStimulus(16'h8000, 16'h1234, 2'b11, 0);
    applyStimulus(16'h0000, 16'h5555, 2'b11, 2);

    // Consumer stall: outputs stay put and a pulsed in_valid is ignored
    out_ready = 1'b0;
    issueOp(16'h1234, 16'h0FF0, 2'b01, e);
    waitValid(lat);
    checkOutput("stall_latency", 32'(lat), 32'(N));
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
      checkOutput("stall_in_ready",  32'(in_ready),  32'd0);
      checkOutput("stall_result",    32'(result),    32'(e.res));
      if (i == 1) begin
        a        = 16'hAAAA;
        b        = 16'h5555;
        mode     = 2'b00;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    waitTransfer();
    checkOutput("post_stall_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < N + 2; i++) begin
      checkOutput("ignored_pulse_no_output", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end

    // Reset asserted in the second BUSY cycle discards the operation
    issueOp(16'h0100, 16'h0001, 2'b01, e);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(sb_q.pop_back());
    checkOutput("midrst_in_ready",  32'(in_ready),  32'd1);
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_result",    32'(result),    32'd0);
    for (int i = 0; i < N + 2; i++) begin
      checkOutput("midrst_no_output", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end

    // Randomised operations with random consumer stalls
    for (int i = 0; i < 40; i++) begin
      applyStimulus(W'($urandom), W'($urandom), 2'($urandom_range(0, 3)),
                    int'($urandom_range(0, 2)));
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
